mem_stage: RTL and testbench

Memory-access stage of the five-stage MIPS pipeline. Consumes the E→M pipeline-register bundle, performs word, halfword and byte loads and stores against an internal data memory, and registers the outcome into the M→W pipeline register. Also drives the W-stage writeback/forwarding triple. Store data is forwarded from that triple when the store's rt was written by the instruction one stage ahead.

---
 rtl/mem_stage_if.sv | 34 +++
 rtl/mem_stage.sv | 138 +++++++++++++
 tb/tb_mem_stage.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Pipeline bundle around the MIPS memory stage: E->M register inputs, M->W register
// outputs and the W-stage writeback/forwarding triple.
interface mem_stage_if;
  logic [31:0] result_M_i;
  logic [4:0]  A2_M_i;
  logic [31:0] RD2_M_i;
  logic [31:0] PCn_M_i;
  logic        regWrite_M_i;
  logic [4:0]  A3_M_i;
  logic [31:0] OP_M_i;

  logic [31:0] result_W_i;
  logic [31:0] PCn_W_i;
  logic [31:0] OP_W_i;
  logic [31:0] memRD_W_i;
  logic [4:0]  A3_W_i;
  logic        regWrite_W_i;

  logic [31:0] W_data;
  logic        W_regWrite;
  logic [4:0]  W_A3;

  modport master (
    output result_M_i, A2_M_i, RD2_M_i, PCn_M_i, regWrite_M_i, A3_M_i, OP_M_i,
    input  result_W_i, PCn_W_i, OP_W_i, memRD_W_i, A3_W_i, regWrite_W_i,
    input  W_data, W_regWrite, W_A3
  );

  modport slave (
    input  result_M_i, A2_M_i, RD2_M_i, PCn_M_i, regWrite_M_i, A3_M_i, OP_M_i,
    output result_W_i, PCn_W_i, OP_W_i, memRD_W_i, A3_W_i, regWrite_W_i,
    output W_data, W_regWrite, W_A3
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory-access stage: word/half/byte loads and stores on internal data memory,
// M->W pipeline register and W-stage store-data forwarding. Define MEM_TRACE_EN to print committed stores.
module mem_stage #(
  parameter int DEPTH = 3072,
  parameter int AW    = 12
) (
  input logic       clk,
  input logic       reset,
  mem_stage_if.slave bus
);

  localparam logic [5:0] OPC_LW  = 6'b100011;
  localparam logic [5:0] OPC_LH  = 6'b100001;
  localparam logic [5:0] OPC_LHU = 6'b100101;
  localparam logic [5:0] OPC_LB  = 6'b100000;
  localparam logic [5:0] OPC_LBU = 6'b100100;
  localparam logic [5:0] OPC_SW  = 6'b101011;
  localparam logic [5:0] OPC_SH  = 6'b101001;
  localparam logic [5:0] OPC_SB  = 6'b101000;

  localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

  logic [31:0] mem [DEPTH];

  logic [5:0]    opc_m;
  logic [AW-1:0] word_idx;
  logic [1:0]    byte_off;
  logic          in_range;
  logic [31:0]   rd_word;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;
  logic [31:0]   load_data;
  logic          is_store;
  logic          fwd;
  logic [31:0]   st_data;
  logic [3:0]    byte_en;
  logic [31:0]   wr_bits;
  logic [31:0]   merged;
  logic          mem_we;
  logic          w_is_load;

  assign opc_m    = bus.OP_M_i[31:26];
  assign word_idx = bus.result_M_i[AW+1:2];
  assign byte_off = bus.result_M_i[1:0];
  assign in_range = (bus.result_M_i[31:AW+2] == '0) && ({1'b0, word_idx} < DEPTH_LIM);
  assign rd_word  = in_range ? mem[word_idx] : '0;
  assign sel_byte = rd_word[8*byte_off +: 8];
  assign sel_half = byte_off[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = '0;
    case (opc_m)
      OPC_LW:  load_data = rd_word;
      OPC_LH:  load_data = {{16{sel_half[15]}}, sel_half};
      OPC_LHU: load_data = {16'h0, sel_half};
      OPC_LB:  load_data = {{24{sel_byte[7]}}, sel_byte};
      OPC_LBU: load_data = {24'h0, sel_byte};
      default: load_data = '0;
    endcase
  end

  // Producer exactly one instruction ahead sits in W; older producers were resolved in D.
  assign fwd     = bus.W_regWrite && (bus.W_A3 == bus.A2_M_i) && (bus.A2_M_i != 5'd0);
  assign st_data = fwd ? bus.W_data : bus.RD2_M_i;

  always_comb begin
    is_store = 1'b0;
    byte_en  = 4'h0;
    wr_bits  = st_data;
    case (opc_m)
      OPC_SW: begin
        is_store = 1'b1;
        byte_en  = 4'hF;
      end
      OPC_SH: begin
        is_store = 1'b1;
        byte_en  = byte_off[1] ? 4'b1100 : 4'b0011;
        wr_bits  = {2{st_data[15:0]}};
      end
      OPC_SB: begin
        is_store = 1'b1;
        byte_en  = 4'b0001 << byte_off;
        wr_bits  = {4{st_data[7:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    merged = rd_word;
    for (int i = 0; i < 4; i++)
      if (byte_en[i]) merged[8*i +: 8] = wr_bits[8*i +: 8];
  end

  assign mem_we = is_store && in_range;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[word_idx] <= merged;
`ifdef MEM_TRACE_EN
      $display("@%h: *%h <= %h", bus.PCn_M_i, {bus.result_M_i[31:2], 2'b00}, merged);
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.result_W_i   <= '0;
      bus.PCn_W_i      <= '0;
      bus.OP_W_i       <= '0;
      bus.memRD_W_i    <= '0;
      bus.A3_W_i       <= '0;
      bus.regWrite_W_i <= 1'b0;
    end else begin
      bus.result_W_i   <= bus.result_M_i;
      bus.PCn_W_i      <= bus.PCn_M_i;
      bus.OP_W_i       <= bus.OP_M_i;
      bus.memRD_W_i    <= load_data;
      bus.A3_W_i       <= bus.A3_M_i;
      bus.regWrite_W_i <= bus.regWrite_M_i;
    end
  end

  always_comb begin
    w_is_load = 1'b0;
    case (bus.OP_W_i[31:26])
      OPC_LW, OPC_LH, OPC_LHU, OPC_LB, OPC_LBU: w_is_load = 1'b1;
      default: w_is_load = 1'b0;
    endcase
  end

  assign bus.W_data     = w_is_load ? bus.memRD_W_i : bus.result_W_i;
  assign bus.W_regWrite = bus.regWrite_W_i;
  assign bus.W_A3       = bus.A3_W_i;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized instruction
// stream compared against a byte-addressed reference memory model.
module tb_mem_stage;
  localparam int DEPTH = 3072;
  localparam int NBYTES = DEPTH * 4;

  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LH  = 6'b100001;
  localparam logic [5:0] LHU = 6'b100101;
  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] SH  = 6'b101001;
  localparam logic [5:0] SB  = 6'b101000;
  localparam logic [5:0] ALU = 6'b000000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  mem_stage_if bus ();

  mem_stage #(.DEPTH(DEPTH), .AW(12)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0]  ref_mem [NBYTES];
  logic [31:0] exp_w_data;
  logic        exp_w_rw;
  logic [4:0]  exp_w_a3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_load_op(input logic [5:0] o);
    return (o == LW) || (o == LH) || (o == LHU) || (o == LB) || (o == LBU);
  endfunction

  function automatic logic [31:0] model_load(input logic [5:0] o, input logic [31:0] a);
    int w, h;
    logic [15:0] hv;
    if (!is_load_op(o) || a >= NBYTES) return 32'h0;
    w = int'(a) & ~3;
    h = int'(a) & ~1;
    hv = {ref_mem[h+1], ref_mem[h]};
    case (o)
      LW:  return {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
      LH:  return {{16{hv[15]}}, hv};
      LHU: return {16'h0, hv};
      LB:  return {{24{ref_mem[a][7]}}, ref_mem[a]};
      default: return {24'h0, ref_mem[a]};
    endcase
  endfunction

  task automatic model_store(input logic [5:0] o, input logic [31:0] a, input logic [31:0] d);
    int w, h;
    if (a >= NBYTES) return;
    w = int'(a) & ~3;
    h = int'(a) & ~1;
    case (o)
      SW: begin
        ref_mem[w] = d[7:0];    ref_mem[w+1] = d[15:8];
        ref_mem[w+2] = d[23:16]; ref_mem[w+3] = d[31:24];
      end
      SH: begin
        ref_mem[h] = d[7:0]; ref_mem[h+1] = d[15:8];
      end
      SB: ref_mem[a] = d[7:0];
      default: ;
    endcase
  endtask

  task automatic model_clear();
    for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h0;
    exp_w_data = '0;
    exp_w_rw = 1'b0;
    exp_w_a3 = '0;
  endtask

  task automatic check_w_zero(input string tag);
    check({tag, "_result"}, bus.result_W_i, 32'h0);
    check({tag, "_pcn"}, bus.PCn_W_i, 32'h0);
    check({tag, "_op"}, bus.OP_W_i, 32'h0);
    check({tag, "_memrd"}, bus.memRD_W_i, 32'h0);
    check({tag, "_a3"}, {27'h0, bus.A3_W_i}, 32'h0);
    check({tag, "_rw"}, {31'h0, bus.regWrite_W_i}, 32'h0);
    check({tag, "_wdata"}, bus.W_data, 32'h0);
    check({tag, "_wrw"}, {31'h0, bus.W_regWrite}, 32'h0);
    check({tag, "_wa3"}, {27'h0, bus.W_A3}, 32'h0);
  endtask

  // Drive one instruction into M, clock it, then compare the W side to the model.
  task automatic step(input logic [31:0] op, input logic [31:0] addr, input logic [4:0] a2,
                      input logic [31:0] rd2, input logic rw, input logic [4:0] a3,
                      input logic [31:0] pc);
    logic [31:0] ld, sd;
    bus.OP_M_i = op;
    bus.result_M_i = addr;
    bus.A2_M_i = a2;
    bus.RD2_M_i = rd2;
    bus.regWrite_M_i = rw;
    bus.A3_M_i = a3;
    bus.PCn_M_i = pc;
    ld = model_load(op[31:26], addr);
    sd = (exp_w_rw && exp_w_a3 == a2 && a2 != 5'd0) ? exp_w_data : rd2;
    model_store(op[31:26], addr, sd);
    @(posedge clk);
    #1;
    exp_w_data = is_load_op(op[31:26]) ? ld : addr;
    exp_w_rw = rw;
    exp_w_a3 = a3;
    check("result_W", bus.result_W_i, addr);
    check("pcn_W", bus.PCn_W_i, pc);
    check("op_W", bus.OP_W_i, op);
    check("memrd_W", bus.memRD_W_i, ld);
    check("a3_W", {27'h0, bus.A3_W_i}, {27'h0, a3});
    check("rw_W", {31'h0, bus.regWrite_W_i}, {31'h0, rw});
    check("W_data", bus.W_data, exp_w_data);
    check("W_regWrite", {31'h0, bus.W_regWrite}, {31'h0, rw});
    check("W_A3", {27'h0, bus.W_A3}, {27'h0, a3});
  endtask

  function automatic logic [31:0] mk(input logic [5:0] o);
    return {o, 26'h0};
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return 32'h2FF0 + $urandom_range(0, 15);
      1:       return 32'h3000 + $urandom_range(0, 15);
      2:       return $urandom;
      default: return $urandom_range(0, 63);
    endcase
  endfunction

  initial begin
    logic [5:0] o;
    bus.OP_M_i = mk(LW);
    bus.result_M_i = 32'h10;
    bus.A2_M_i = '0;
    bus.RD2_M_i = '0;
    bus.regWrite_M_i = 1'b1;
    bus.A3_M_i = 5'd7;
    bus.PCn_M_i = 32'h400;
    model_clear();

    // Reset held for two edges with a live lw on the inputs.
    repeat (2) begin
      @(posedge clk);
      #1;
      check_w_zero("rst");
    end
    reset = 1'b0;
    step(mk(LW), 32'h10, 5'd0, 32'h0, 1'b1, 5'd2, 32'h1000);
    check("plan_lw_after_rst", bus.memRD_W_i, 32'h0);

    step(mk(SW), 32'h20, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'h1004);
    step(mk(LW), 32'h20, 5'd0, 32'h0, 1'b1, 5'd3, 32'h1008);
    check("plan_sw_lw", bus.W_data, 32'h12345678);

    step(mk(SW), 32'h20, 5'd0, 32'h0, 1'b0, 5'd0, 32'h100C);
    step(mk(SB), 32'h23, 5'd0, 32'h80, 1'b0, 5'd0, 32'h1010);
    step(mk(SH), 32'h20, 5'd0, 32'hBEEF, 1'b0, 5'd0, 32'h1014);
    step(mk(LW), 32'h20, 5'd0, 32'h0, 1'b1, 5'd4, 32'h1018);
    check("plan_lw_merge", bus.W_data, 32'h8000BEEF);
    step(mk(LB), 32'h23, 5'd0, 32'h0, 1'b1, 5'd4, 32'h101C);
    check("plan_lb", bus.W_data, 32'hFFFFFF80);
    step(mk(LBU), 32'h23, 5'd0, 32'h0, 1'b1, 5'd4, 32'h1020);
    check("plan_lbu", bus.W_data, 32'h00000080);
    step(mk(LH), 32'h20, 5'd0, 32'h0, 1'b1, 5'd4, 32'h1024);
    check("plan_lh", bus.W_data, 32'hFFFFBEEF);
    step(mk(LHU), 32'h22, 5'd0, 32'h0, 1'b1, 5'd4, 32'h1028);
    check("plan_lhu", bus.W_data, 32'h00008000);

    step(mk(ALU), 32'hCAFEF00D, 5'd0, 32'h0, 1'b1, 5'd5, 32'h102C);
    step(mk(SW), 32'h40, 5'd5, 32'h1, 1'b0, 5'd0, 32'h1030);
    step(mk(LW), 32'h40, 5'd0, 32'h0, 1'b1, 5'd6, 32'h1034);
    check("plan_fwd", bus.W_data, 32'hCAFEF00D);
    step(mk(ALU), 32'hCAFEF00D, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1038);
    step(mk(SW), 32'h44, 5'd0, 32'h1, 1'b0, 5'd0, 32'h103C);
    step(mk(LW), 32'h44, 5'd0, 32'h0, 1'b1, 5'd6, 32'h1040);
    check("plan_nofwd_r0", bus.W_data, 32'h1);

    step(mk(SW), 32'h2FFC, 5'd0, 32'h5A5A5A5A, 1'b0, 5'd0, 32'h1044);
    step(mk(SW), 32'h3000, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h1048);
    step(mk(LW), 32'h3000, 5'd0, 32'h0, 1'b1, 5'd1, 32'h104C);
    check("plan_oor_lw", bus.W_data, 32'h0);
    step(mk(LW), 32'h2FFC, 5'd0, 32'h0, 1'b1, 5'd1, 32'h1050);
    check("plan_oor_top", bus.W_data, 32'h5A5A5A5A);
    step(mk(LW), 32'h0, 5'd0, 32'h0, 1'b1, 5'd1, 32'h1054);
    check("plan_oor_low", bus.W_data, 32'h0);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0: o = LW;  1: o = LH;  2: o = LHU; 3: o = LB;  4: o = LBU;
        5: o = SW;  6: o = SH;  7: o = SB;
        default: o = 6'($urandom);
      endcase
      step({o, 26'($urandom)}, rand_addr(), 5'($urandom_range(0, 3)), $urandom,
           1'($urandom), 5'($urandom_range(0, 3)), $urandom);
    end

    // Asynchronous reset pulse between edges, right after a store commits.
    step(mk(SW), 32'h8, 5'd0, 32'hAA, 1'b1, 5'd9, 32'h2000);
    #2 reset = 1'b1;
    #1 check_w_zero("async_rst");
    #1 reset = 1'b0;
    model_clear();
    step(mk(LW), 32'h8, 5'd0, 32'h0, 1'b1, 5'd9, 32'h2004);
    check("plan_async_lw", bus.W_data, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
